// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed seven-segment driver.
// Each frame scans digits 0..3. All four BCD digits are captured together
// at frame boundaries, so a counter carry never shows as a torn display.
// Per-digit blinking and leading-zero suppression on the minutes-tens digit
// use live controls. The anode, segment and DP lines are registered and
// active-low.
module seg7_scan #(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 250
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [2:0] MINH,
   input  logic [3:0] MINL,
   input  logic [2:0] SECH,
   input  logic [3:0] SECL,
   input  logic       LZB,
   input  logic [3:0] BLINK,
   input  logic       DP_EN,
   output logic [3:0] AN,
   output logic [6:0] SEG,
   output logic       DP
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);

   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          ph_q, ph_d;
   logic [2:0]    s3_q, s3_d;
   logic [3:0]    s2_q, s2_d;
   logic [2:0]    s1_q, s1_d;
   logic [3:0]    s0_q, s0_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          tick;
   logic          frame_end;
   logic [3:0]    cur_digit;
   logic          blank;

   // Active-low segment pattern for one BCD digit; non-BCD values show a dash.
   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] r;
      case (v)
         4'd0:    r = 7'b1000000;
         4'd1:    r = 7'b1111001;
         4'd2:    r = 7'b0100100;
         4'd3:    r = 7'b0110000;
         4'd4:    r = 7'b0011001;
         4'd5:    r = 7'b0010010;
         4'd6:    r = 7'b0000010;
         4'd7:    r = 7'b1111000;
         4'd8:    r = 7'b0000000;
         4'd9:    r = 7'b0010000;
         default: r = 7'b0111111;
      endcase
      return r;
   endfunction

   // Scan timing: prescaler, digit index, frame counter, blink phase, snapshot.
   always_comb begin
      tick      = (pcnt_q == PCNT_MAX);
      frame_end = tick && (idx_q == 2'd3);
      pcnt_d    = tick ? '0 : pcnt_q + 1'b1;
      idx_d     = tick ? idx_q + 2'd1 : idx_q;
      fcnt_d    = fcnt_q;
      ph_d      = ph_q;
      s3_d      = s3_q;
      s2_d      = s2_q;
      s1_d      = s1_q;
      s0_d      = s0_q;
      if (frame_end) begin
         // The snapshot load and the blink toggle land on the same edge as
         // the index wrap, so digit 0 of the new frame sees both at once.
         s3_d = MINH;
         s2_d = MINL;
         s1_d = SECH;
         s0_d = SECL;
         if (fcnt_q == FCNT_MAX) begin
            fcnt_d = '0;
            ph_d   = ~ph_q;
         end else begin
            fcnt_d = fcnt_q + 1'b1;
         end
      end
   end

   // Display for the current slot; only the snapshot feeds the decode.
   always_comb begin
      case (idx_q)
         2'd0:    cur_digit = s0_q;
         2'd1:    cur_digit = {1'b0, s1_q};
         2'd2:    cur_digit = s2_q;
         default: cur_digit = {1'b0, s3_q};
      endcase
      blank = (BLINK[idx_q] && ph_q) ||
              ((idx_q == 2'd3) && LZB && (s3_q == 3'd0));
      an_d  = 4'b1111;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (!blank) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = decode(cur_digit);
         dp_d  = !((idx_q == 2'd2) && DP_EN);
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pcnt_q <= '0;
         idx_q  <= 2'd0;
         fcnt_q <= '0;
         ph_q   <= 1'b0;
         s3_q   <= 3'd0;
         s2_q   <= 4'd0;
         s1_q   <= 3'd0;
         s0_q   <= 4'd0;
         an_q   <= 4'b1111;
         seg_q  <= 7'h7F;
         dp_q   <= 1'b1;
      end else begin
         pcnt_q <= pcnt_d;
         idx_q  <= idx_d;
         fcnt_q <= fcnt_d;
         ph_q   <= ph_d;
         s3_q   <= s3_d;
         s2_q   <= s2_d;
         s1_q   <= s1_d;
         s0_q   <= s0_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
         dp_q   <= dp_d;
      end
   end

   assign AN  = an_q;
   assign SEG = seg_q;
   assign DP  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan with a small scan period and a short blink period.
// The model derives the slot, frame and blink phase from the number of
// cycles since reset, and keeps its own copy of the four captured digits.
// Directed literal checks pin the model at chosen cycles.
module tb_seg7_scan;

  localparam int D  = 4;
  localparam int BF = 2;

  logic       clk;
  logic       rst;
  logic [2:0] minh;
  logic [3:0] minl;
  logic [2:0] sech;
  logic [3:0] secl;
  logic       lzb;
  logic [3:0] blink;
  logic       dp_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int pos;

  seg7_scan #(.SCAN_DIV(D), .BLINK_FRAMES(BF)) dut (
    .CLK(clk), .RST(rst), .MINH(minh), .MINL(minl), .SECH(sech), .SECL(secl),
    .LZB(lzb), .BLINK(blink), .DP_EN(dp_en), .AN(an), .SEG(seg), .DP(dp)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // model + per-cycle compare
  int         mc = 0;
  logic [3:0] ms [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;

  always begin
    int di, frame, ph;
    bit bl;
    @(posedge clk);
    if (rst) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      mc = 0;
      for (int k = 0; k < 4; k++) ms[k] = 4'd0;
    end else begin
      di    = (mc / D) % 4;
      frame = mc / (4 * D);
      ph    = (frame / BF) % 2;
      bl    = (blink[di] && ph == 1) || (di == 3 && lzb && ms[3] == 4'd0);
      if (bl) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an  = 4'hF;
        e_an[di] = 1'b0;
        e_seg = seg_of(ms[di]);
        e_dp  = !(di == 2 && dp_en);
      end
      if (mc % (4 * D) == 4 * D - 1) begin
        ms[0] = secl;
        ms[1] = {1'b0, sech};
        ms[2] = minl;
        ms[3] = {1'b0, minh};
      end
      mc++;
    end
    #1;
    chk("model_an",  {3'b0, an}, {3'b0, e_an});
    chk("model_seg", seg, e_seg);
    chk("model_dp",  {6'b0, dp}, {6'b0, e_dp});
  end

  // advance to the negedge after non-reset edge number c
  task automatic to_cycle(input int c);
    while (pos < c) begin
      @(negedge clk);
      pos++;
    end
  endtask

  // stimulus + directed checks
  initial begin
    rst = 1'b1; minh = 3'd5; minl = 4'd9; sech = 3'd5; secl = 4'd9;
    lzb = 1'b0; blink = 4'b0000; dp_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_an",  {3'b0, an}, 7'h0F);
    chk("reset_seg", seg, 7'h7F);
    chk("reset_dp",  {6'b0, dp}, 7'h01);
    rst = 1'b0;
    pos = -1;

    to_cycle(0);  chk("scan_d0_an", {3'b0, an}, 7'h0E); chk("scan_d0_seg", seg, 7'h40);
    to_cycle(1);  minh = 3'd1; minl = 4'd2; sech = 3'd3; secl = 4'd4;
    to_cycle(4);  chk("scan_d1_an", {3'b0, an}, 7'h0D); chk("scan_d1_seg", seg, 7'h40);
    to_cycle(8);  chk("scan_d2_an", {3'b0, an}, 7'h0B);
    to_cycle(12); chk("scan_d3_an", {3'b0, an}, 7'h07); chk("scan_d3_seg", seg, 7'h40);

    to_cycle(16); chk("snap_d0", seg, 7'h19);
    to_cycle(20); chk("snap_d1", seg, 7'h30);
    to_cycle(21); secl = 4'd7;
    to_cycle(24); chk("snap_d2", seg, 7'h24);
    to_cycle(28); chk("snap_d3", seg, 7'h79);
    to_cycle(32); chk("snap_new_d0", seg, 7'h78);

    to_cycle(33); secl = 4'hB; minh = 3'd0; lzb = 1'b1;
    to_cycle(48); chk("bad_bcd_d0", seg, 7'h3F);
    to_cycle(60); chk("lzb_an", {3'b0, an}, 7'h0F); chk("lzb_seg", seg, 7'h7F);
    to_cycle(61); lzb = 1'b0;
    to_cycle(62); chk("nolzb_an", {3'b0, an}, 7'h07); chk("nolzb_seg", seg, 7'h40);

    to_cycle(63); blink = 4'b0100; dp_en = 1'b1;
    to_cycle(72); chk("blk_vis_an", {3'b0, an}, 7'h0B); chk("blk_vis_dp", {6'b0, dp}, 7'h00);
    chk("blk_vis_seg", seg, 7'h24);
    to_cycle(96); chk("blk_d0_an", {3'b0, an}, 7'h0E);
    to_cycle(104); chk("blk_hid_an", {3'b0, an}, 7'h0F); chk("blk_hid_dp", {6'b0, dp}, 7'h01);

    to_cycle(105); rst = 1'b1;
    @(negedge clk); chk("mid_rst_an", {3'b0, an}, 7'h0F);
    rst = 1'b0;
    @(negedge clk); chk("post_rst_an", {3'b0, an}, 7'h0E); chk("post_rst_seg", seg, 7'h40);
    repeat (8) @(negedge clk);
    chk("post_rst_ph_an", {3'b0, an}, 7'h0B); chk("post_rst_ph_dp", {6'b0, dp}, 7'h00);
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Four-digit multiplexed seven-segment display driver for the Nexys 3 clock design. It consumes the BCD minute and second digits produced by the counter chain (tens 0-5, units 0-9). It drives the board's shared, active-low anode and segment lines. Each frame's digits are sampled together so a carry rippling through the counters never shows as a torn display. It also handles per-digit blinking for time-set mode and leading-zero suppression.

## Interface
- SCAN_DIV, 50000: CLK cycles per digit slot (100 MHz gives 2 kHz per digit and a 500 Hz frame rate); legal range ≥ 2.
- BLINK_FRAMES, 250: number of completed frames per blink-phase toggle (1 Hz blink at defaults); legal range ≥ 1.
- CLK  in  1  system clock; all logic on posedge.
- RST  in  1  reset, synchronous, active-high.
- MINH  in  3  minutes tens digit, BCD.
- MINL  in  4  minutes units digit, BCD.
- SECH  in  3  seconds tens digit, BCD.
- SECL  in  4  seconds units digit, BCD.
- LZB  in  1  1 = blank digit 3 when the snapshot MINH == 0.
- BLINK  in  4  per-digit blink enable; bit i ↔ digit i.
- DP_EN  in  1  1 = light the decimal point on digit 2 (mm.ss separator).
- AN  out  4  anodes, active-low; AN[0] = rightmost digit (SECL), AN[3] = MINH.
- SEG  out  7  cathodes, active-low; SEG[0]=a … SEG[6]=g.
- DP  out  1  decimal-point cathode, active-low.

## Operation
- Prescaler PCNT counts 0 … SCAN_DIV-1 and wraps to 0. TICK = (PCNT == SCAN_DIV-1).
- Digit index IDX (2 bits) increments on TICK: 0→1→2→3→0.
- Snapshot registers S3..S0 hold MINH, MINL, SECH, SECL.
  - They load on TICK with IDX == 3, i.e. the same edge IDX wraps to 0.
  - Inputs are otherwise ignored. A new value appears starting at digit 0 of the next frame.
- Frame counter FCNT counts completed frames (TICK with IDX == 3), 0 … BLINK_FRAMES-1.
  - On wrap it toggles PH. PH = 0 means the visible phase.
- Digit i is blanked (AN[i] stays 1, SEG = 7'h7F, DP = 1) when either condition holds:
  - BLINK[i] = 1 and PH = 1;
  - i == 3, LZB = 1 and S3 == 0.
- Otherwise AN = ~(1 << IDX) and SEG = decode(S[IDX]).
- Decode, SEG[6:0] active-low:
  - 0=7'b1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any value > 9 decodes to a dash: 0111111 (g only).
  - Tens digits are zero-extended to 4 bits before decode.
- DP = 0 only while IDX == 2, DP_EN = 1 and digit 2 is not blanked; otherwise 1.
- BLINK, LZB and DP_EN are used live, not snapshotted.

## Timing
- AN, SEG and DP are registered and computed from the current IDX, snapshot, PH and the live controls. Outputs change one cycle after IDX changes.
- On any CLK edge with RST = 1:
  - PCNT = 0, IDX = 0, FCNT = 0, PH = 0, S3..S0 = 0;
  - AN = 4'b1111, SEG = 7'h7F, DP = 1.
- First edge with RST = 0: AN = 1110, SEG = 1000000 (digit 0 shows "0").
- Each digit holds for exactly SCAN_DIV cycles; one frame is 4·SCAN_DIV cycles.
- Exactly one AN bit is low at any time, or none when blanked or in reset.
- Simultaneous frame wrap and FCNT wrap on the same edge: snapshot load and PH toggle both take effect. The first digit of the new frame uses the new snapshot and the new PH.
- RST mid-frame: the scan restarts at digit 0 on the next edge. The snapshot is cleared, so the display shows 0000 until the first frame completes.
- Inputs may change on any cycle with no glitch on the outputs, because only the snapshot feeds the decode.

## Test plan
All scenarios run with SCAN_DIV = 4 and BLINK_FRAMES = 2.

- Reset / scan order:
  - Stimulus: assert RST for 3 cycles, then release with inputs 5,9,5,9.
  - Required response: AN = 1111 during reset; then AN steps 1110, 1101, 1011, 0111, each for 4 cycles; SEG = "0" for the whole first frame.
- Snapshot:
  - Stimulus: MINH=1, MINL=2, SECH=3, SECL=4.
  - Required response: the second frame shows SEG 0011001, 0110000, 0100100, 1111001 on digits 0-3.
  - Stimulus: change SECL to 7 mid-frame.
  - Required response: the current frame still shows 4; "7" (1111000) appears only on the next frame's digit 0.
- Invalid BCD:
  - Stimulus: SECL = 4'hB.
  - Required response: digit 0 SEG = 0111111.
- Leading zero:
  - Stimulus: MINH = 0, LZB = 1.
  - Required response: in the digit-3 slot AN = 1111 and SEG = 7F.
  - Stimulus: LZB = 0.
  - Required response: AN = 0111 and SEG = 1000000.
- Blink + DP:
  - Stimulus: BLINK = 0100, DP_EN = 1.
  - Required response:
    - frames 1-2 (PH = 0): digit 2 lit and DP = 0 in the digit-2 slot;
    - frames 3-4 (PH = 1): in the digit-2 slot AN = 1111 and DP = 1;
    - digits 0, 1 and 3 unaffected throughout.
- Reset mid-frame:
  - Stimulus: pulse RST while IDX = 2.
  - Required response: next edge AN = 1111; following edge AN = 1110 showing "0"; PH = 0.
